// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the
// surroundings' view: the two requesting ports plus the memory.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between an instruction-fetch port and a
// load/store port. Grants and the memory strobe are combinational in the
// request cycle; read data comes back one cycle later. A response-owner
// register routes it to the port that issued the read. Load/store has
// priority, but a starvation counter forces a fetch win after STARVE_MAX
// consecutive denied fetch cycles.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t        own_p1;
  owner_t        own_nxt;
  logic [3:0]    starve_cnt;
  logic [3:0]    starve_nxt;
  logic          force_if;
  logic          gnt_if;
  logic          gnt_ls;
  logic          en_p0;
  logic          we_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;

  // Saturating increment keeps the 4-bit counter from wrapping back to zero.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? 4'hF : c + 4'd1;
  endfunction

  // Arbitration, memory-side mux and next owner/counter, all in the request cycle.
  always_comb begin
    gnt_if     = 1'b0;
    gnt_ls     = 1'b0;
    en_p0      = 1'b0;
    we_p0      = 1'b0;
    addr_p0    = '0;
    wdata_p0   = '0;
    own_nxt    = OWN_NONE;
    starve_nxt = 4'd0;
    force_if   = bus.if_req && (starve_cnt == STARVE_LIM);

    if (!rst) begin
      if (force_if)        gnt_if = 1'b1;
      else if (bus.ls_req) gnt_ls = 1'b1;
      else if (bus.if_req) gnt_if = 1'b1;
    end

    if (gnt_if) begin
      en_p0   = 1'b1;
      addr_p0 = bus.if_addr;
      own_nxt = OWN_IF;
    end else if (gnt_ls) begin
      en_p0    = 1'b1;
      we_p0    = bus.ls_we;
      addr_p0  = bus.ls_addr;
      wdata_p0 = bus.ls_wdata;
      own_nxt  = bus.ls_we ? OWN_NONE : OWN_LS;
    end

    // Only a denied, still-pending fetch request keeps counting.
    if (bus.if_req && !gnt_if) starve_nxt = sat_inc(starve_cnt);
  end

  // Response owner and starvation counter; reset discards any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_p1     <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      own_p1     <= own_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // ---- stage p0: request-cycle outputs ----
  assign bus.if_gnt    = gnt_if;
  assign bus.ls_gnt    = gnt_ls;
  assign bus.mem_en    = en_p0;
  assign bus.mem_we    = we_p0;
  assign bus.mem_addr  = addr_p0;
  assign bus.mem_wdata = wdata_p0;

  // ---- stage p1: read data returned to the owning port ----
  assign bus.if_rvalid = (own_p1 == OWN_IF);
  assign bus.ls_rvalid = (own_p1 == OWN_LS);
  assign bus.if_rdata  = (own_p1 == OWN_IF) ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = (own_p1 == OWN_LS) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed per-cycle grant expectations plus a
// response scoreboard fed by a small memory model with one-cycle read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    logic        ls;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0101_0001;
  endfunction

  // Memory model: one-cycle read latency, junk on the data bus when not reading.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      bus.mem_rdata <= 32'h5A5A_0000;
    end else if (bus.mem_en && !bus.mem_we) begin
      bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end else begin
      bus.mem_rdata <= 32'h5A5A_0000 ^ 32'(cyc);
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check the response owed from the previous cycle, then the
  // grant/memory outputs for the current inputs, then record owed responses.
  task automatic step(input string tag, input logic e_if, input logic e_ls);
    rsp_t        r;
    logic [31:0] ea;
    logic [31:0] ew;
    logic        ewe;
    @(negedge clk);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, ".if_rvalid"}, 64'(bus.if_rvalid), 64'(!r.ls));
      chk({tag, ".ls_rvalid"}, 64'(bus.ls_rvalid), 64'(r.ls));
      chk({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'(r.ls ? 32'd0 : r.data));
      chk({tag, ".ls_rdata"}, 64'(bus.ls_rdata), 64'(r.ls ? r.data : 32'd0));
    end else begin
      chk({tag, ".if_rvalid"}, 64'(bus.if_rvalid), 64'd0);
      chk({tag, ".ls_rvalid"}, 64'(bus.ls_rvalid), 64'd0);
      chk({tag, ".if_rdata"}, 64'(bus.if_rdata), 64'd0);
      chk({tag, ".ls_rdata"}, 64'(bus.ls_rdata), 64'd0);
    end
    ea  = e_if ? bus.if_addr : (e_ls ? bus.ls_addr : 32'd0);
    ewe = e_ls & bus.ls_we;
    ew  = e_ls ? bus.ls_wdata : 32'd0;
    chk({tag, ".if_gnt"}, 64'(bus.if_gnt), 64'(e_if));
    chk({tag, ".ls_gnt"}, 64'(bus.ls_gnt), 64'(e_ls));
    chk({tag, ".mem_en"}, 64'(bus.mem_en), 64'(e_if | e_ls));
    chk({tag, ".mem_we"}, 64'(bus.mem_we), 64'(ewe));
    chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(ea));
    chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(ew));
    if (e_if) sb.push_back('{1'b0, shadow[bus.if_addr[7:2]]});
    if (e_ls && !bus.ls_we) sb.push_back('{1'b1, shadow[bus.ls_addr[7:2]]});
    if (e_ls && bus.ls_we) shadow[bus.ls_addr[7:2]] = bus.ls_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = 32'd0;
    bus.ls_wdata = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    rst = 1'b1;
    idle_inputs();
    // Requests during reset must not be granted.
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.ls_req = 1'b1; bus.ls_addr = 32'h24; bus.ls_wdata = 32'h1234_5678;
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    idle_inputs();
    rst = 1'b0;
    step("idle", 1'b0, 1'b0);

    // Single fetch read.
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    step("if_rd", 1'b1, 1'b0);
    idle_inputs();
    step("if_rsp", 1'b0, 1'b0);

    // Simultaneous requests: ls first, fetch next cycle alongside ls response.
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    bus.ls_req = 1'b1; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0BAD_F00D;
    step("both_ls", 1'b0, 1'b1);
    bus.ls_req = 1'b0;
    step("both_if", 1'b1, 1'b0);
    idle_inputs();
    step("both_rsp", 1'b0, 1'b0);

    // Write then read back the same word.
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'hC; bus.ls_wdata = 32'hDEAD_BEEF;
    step("wr", 1'b0, 1'b1);
    idle_inputs();
    step("wr_norsp", 1'b0, 1'b0);
    bus.ls_req = 1'b1; bus.ls_addr = 32'hC;
    step("rdback", 1'b0, 1'b1);
    idle_inputs();
    step("rdback_rsp", 1'b0, 1'b0);

    // Starvation: both held, fetch wins every 5th cycle.
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.ls_req = 1'b1; bus.ls_addr = 32'h14;
    for (int k = 1; k <= 15; k++) begin
      step($sformatf("starve%0d", k), (k % 5) == 0, (k % 5) != 0);
    end
    idle_inputs();
    step("starve_end", 1'b0, 1'b0);

    // Dropping the fetch request clears the counter.
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    bus.ls_req = 1'b1; bus.ls_addr = 32'h34;
    step("clr_a", 1'b0, 1'b1);
    step("clr_b", 1'b0, 1'b1);
    bus.if_req = 1'b0;
    step("clr_drop", 1'b0, 1'b1);
    bus.if_req = 1'b1;
    for (int k = 1; k <= 4; k++) step($sformatf("clr_ls%0d", k), 1'b0, 1'b1);
    step("clr_if", 1'b1, 1'b0);
    idle_inputs();
    step("clr_end", 1'b0, 1'b0);

    // Reset right after a load grant discards its response.
    bus.ls_req = 1'b1; bus.ls_addr = 32'h18;
    step("rstmid_gnt", 1'b0, 1'b1);
    rst = 1'b1;
    sb.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h1C;
    step("rstmid0", 1'b0, 1'b0);
    step("rstmid1", 1'b0, 1'b0);
    idle_inputs();
    rst = 1'b0;
    step("rstmid_after", 1'b0, 1'b0);

    // Alternating single-port reads, one per cycle.
    for (int k = 0; k < 8; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 32'(k * 4 + 64);
      end else begin
        bus.ls_req = 1'b1; bus.ls_addr = 32'(k * 4 + 64);
      end
      step($sformatf("alt%0d", k), (k % 2) == 0, (k % 2) != 0);
    end
    idle_inputs();
    step("alt_end", 1'b0, 1'b0);
    step("final_idle", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter STARVE_MAX, default 4, range 1..15, consecutive denied fetch-request cycles before fetch is forced to win.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 if_req  input  1  fetch port read request; held high until granted.
REQ-007 if_addr  input  AW  fetch byte address; stable while if_req is high and ungranted.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid this cycle.
REQ-010 if_rdata  output  DW  fetch read data.
REQ-011 ls_req  input  1  load/store port request; held high until granted.
REQ-012 ls_we  input  1  1 = write, 0 = read.
REQ-013 ls_addr  input  AW  load/store byte address.
REQ-014 ls_wdata  input  DW  store data.
REQ-015 ls_gnt  output  1  load/store request accepted this cycle.
REQ-016 ls_rvalid  output  1  load read data valid this cycle.
REQ-017 ls_rdata  output  DW  load read data.
REQ-018 mem_en  output  1  memory access strobe.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  AW  memory byte address; word index is mem_addr[AW-1:2].
REQ-021 mem_wdata  output  DW  memory write data.
REQ-022 mem_rdata  input  DW  memory read data, valid one cycle after a read strobe.

Function
REQ-023 The block shall issue at most one grant per cycle; grant, mem_en, and the selected port's addr/we/wdata on mem_* shall be combinational in the same cycle as the winning req.
REQ-024 Default priority: ls over if; if only one port requests, that port wins.
REQ-025 Starvation counter (4 bits): +1 each cycle if_req=1 and if_gnt=0; cleared on any if_gnt or when if_req=0.
REQ-026 When counter == STARVE_MAX and if_req=1, fetch shall win over ls that cycle and the counter shall clear.
REQ-027 Fetch grants shall drive mem_we=0 and mem_wdata=0.
REQ-028 With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Response owner register (2 bits: none/if/ls) shall capture the granted read port at each edge; a write grant or no grant captures none.
REQ-030 if_rvalid=1 exactly one cycle after an if_gnt; ls_rvalid=1 exactly one cycle after an ls_gnt with ls_we=0; never both.
REQ-031 if_rdata and ls_rdata shall equal mem_rdata while their rvalid is 1, and 0 otherwise.
REQ-032 Back-to-back grants every cycle shall be supported; a response and a new grant may coincide in the same cycle.
REQ-033 A write shall produce no rvalid on either port.
REQ-034 Deasserting a req without a grant shall be legal and shall leave no state other than the counter clear of REQ-025.

Reset
REQ-035 While rst=1: if_gnt=0, ls_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, both rvalid=0, both rdata=0, counter=0, owner=none.
REQ-036 Assertion of rst mid-operation shall discard any outstanding response; no rvalid in the first cycle after deassertion.
REQ-037 Normal arbitration shall resume on the first rising edge after rst deasserts.

Verification
REQ-038 if_req=1, if_addr=0x8, ls idle -> if_gnt=1, mem_en=1, mem_addr=0x8 same cycle; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-039 Same cycle if_req=1 (0x4) and ls_req=1 read (0x0) -> ls_gnt=1, if_gnt=0; next cycle ls_rvalid=1 and if_gnt=1 with mem_addr=0x4.
REQ-040 ls_req=1, ls_we=1, ls_addr=0xC, ls_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; no rvalid on the next cycle.
REQ-041 ls_req held high continuously with if_req high, STARVE_MAX=4 -> if_gnt on the 5th cycle only, then ls wins the next 4 cycles; repeating pattern.
REQ-042 ls read granted, rst pulsed on the next edge -> ls_rvalid stays 0; all outputs 0 during and one cycle after reset.
REQ-043 Alternating if/ls reads over 8 cycles -> each rvalid lands on the correct port, one cycle after its grant, with no drops or duplicates.
